// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_pkg
// Description : Shared types and the condition-evaluation helper for the
//               conditional-branch resolver.
// Revision    : 1.0 - initial release
// ============================================================================
package branch_pkg;

    // Condition codes carried on branch_cond
    typedef enum logic [2:0] {
        COND_ALWAYS = 3'b000,
        COND_EQ     = 3'b001,
        COND_NE     = 3'b010,
        COND_LT     = 3'b011,
        COND_GE     = 3'b100,
        COND_GT     = 3'b101,
        COND_LE     = 3'b110,
        COND_NEVER  = 3'b111
    } branch_cond_t;

    // Resolver FSM states, explicitly encoded
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FLAGS = 2'd1,
        DONE       = 2'd2
    } branch_state_t;

    // Returns 1 when the condition holds for the given Z/N flags
    function automatic logic cond_taken(
        input branch_cond_t cond,
        input logic         z,
        input logic         n
    );
        logic w_taken;
        case (cond)
            COND_ALWAYS: w_taken = 1'b1;
            COND_EQ:     w_taken = z;
            COND_NE:     w_taken = !z;
            COND_LT:     w_taken = n;
            COND_GE:     w_taken = !n;
            COND_GT:     w_taken = !n && !z;
            COND_LE:     w_taken = n || z;
            default:     w_taken = 1'b0;   // COND_NEVER
        endcase
        return w_taken;
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_cond_eval.sv
`default_nettype none
// ============================================================================
// Module      : branch_cond_eval
// Description : Combinational branch-condition evaluation on Z/N flags.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_cond_eval
    import branch_pkg::*;
(
    input  logic [2:0] i_cond,
    input  logic       i_flag_z,
    input  logic       i_flag_n,
    output logic       o_taken
);

    // Pure decode of the condition code against the flags
    assign o_taken = cond_taken(branch_cond_t'(i_cond), i_flag_z, i_flag_n);

endmodule
`default_nettype wire

// File: rtl/branch_resolver.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolver
// Description : Resolves conditional-branch requests against the status
//               flags, waiting out any flag write in flight, and issues a
//               one-cycle PC-load command plus a saturating taken counter.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolver
    import branch_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   branch_reset_n,
    input  logic                   branch_req,
    input  logic [2:0]             branch_cond,
    input  logic [ADDR_WIDTH-1:0]  branch_target,
    input  logic                   flag_Z,
    input  logic                   flag_N,
    input  logic                   status_wr,
    output logic                   branch_ack,
    output logic                   pc_load,
    output logic [ADDR_WIDTH-1:0]  pc_target,
    output logic                   branch_busy,
    output logic [COUNT_WIDTH-1:0] taken_count
);

    localparam logic [COUNT_WIDTH-1:0] c_count_max = '1;

    branch_state_t          r_state;
    branch_cond_t           r_cond;
    logic [ADDR_WIDTH-1:0]  r_target;
    logic                   r_ack;
    logic                   r_load;
    logic [ADDR_WIDTH-1:0]  r_pc_target;
    logic                   r_busy;
    logic [COUNT_WIDTH-1:0] r_count;

    logic [2:0]             w_eval_cond;
    logic [ADDR_WIDTH-1:0]  w_eval_target;
    logic                   w_taken;
    logic                   w_resolve;

    // In IDLE the request is evaluated straight off the inputs (same cycle
    // it is latched); in WAIT_FLAGS the latched copy is used so later
    // changes on the request bus cannot leak in.
    assign w_eval_cond   = (r_state == IDLE) ? branch_cond   : r_cond;
    assign w_eval_target = (r_state == IDLE) ? branch_target : r_target;

    // Resolution happens only when no flag write is in flight this cycle
    assign w_resolve = !status_wr &&
                       (((r_state == IDLE) && branch_req) || (r_state == WAIT_FLAGS));

    branch_cond_eval u_cond_eval (
        .i_cond   (w_eval_cond),
        .i_flag_z (flag_Z),
        .i_flag_n (flag_N),
        .o_taken  (w_taken)
    );

    // FSM, request latches, registered outputs and taken counter
    always_ff @(posedge clock) begin
        if (!branch_reset_n) begin
            r_state     <= IDLE;
            r_cond      <= COND_ALWAYS;
            r_target    <= '0;
            r_ack       <= 1'b0;
            r_load      <= 1'b0;
            r_pc_target <= '0;
            r_busy      <= 1'b0;
            r_count     <= '0;
        end else begin
            r_ack  <= 1'b0;
            r_load <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (branch_req) begin
                        r_cond   <= branch_cond_t'(branch_cond);
                        r_target <= branch_target;
                        r_busy   <= 1'b1;
                        r_state  <= status_wr ? WAIT_FLAGS : DONE;
                    end
                end
                WAIT_FLAGS: begin
                    if (!status_wr) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            // Entering DONE: present ack/pc_load for exactly the DONE cycle
            if (w_resolve) begin
                r_ack  <= 1'b1;
                r_load <= w_taken;
                if (w_taken) begin
                    r_pc_target <= w_eval_target;
                    if (r_count != c_count_max) begin
                        r_count <= r_count + 1'b1;
                    end
                end
            end
        end
    end

    assign branch_ack  = r_ack;
    assign pc_load     = r_load;
    assign pc_target   = r_pc_target;
    assign branch_busy = r_busy;
    assign taken_count = r_count;

endmodule
`default_nettype wire
